clock_time_keeper: RTL
======================

// Module: clock_time_keeper
// PURPOSE
//  12-hour time-of-day counter (hh:mm:ss + AM/PM) with button-driven time setting.
//  Sits directly upstream of the VGA clock renderer and drives its h1,h2,m1,m2,s1,s2,ap buses.
//  Each bus is a registered 7-bit active-low segment code: bit6=a, bit5=b ... bit0=g.
// PARAMETERS
//  TICK_DIV      100_000_000  CLK cycles per second; set to 10 in simulation
//  DEBOUNCE_CYC  1_000_000    CLK cycles a synchronised button must hold stable before it is accepted
// PORTS
//  CLK       in   1  system clock, 100 MHz
//  RST       in   1  synchronous reset, active-high
//  BTN_MODE  in   1  raw async button, active-high; cycles the mode
//  BTN_INC   in   1  raw async button, active-high; increments the selected field
//  h1,h2     out  7  hour tens/ones segment codes
//  m1,m2     out  7  minute tens/ones segment codes
//  s1,s2     out  7  second tens/ones segment codes
//  ap        out  7  'A' = 7'b0001000, 'P' = 7'b0011000
//  tick_1hz  out  1  one-CLK pulse per elapsed second, RUN mode only
// BEHAVIOUR
//  Digit codes:
//   0=0000001  1=1001111  2=0010010  3=0000110  4=1001100
//   5=0100100  6=0100000  7=0001111  8=0000000  9=0000100  blank=1111111
//  Reset (state applies on the next edge):
//   - time = 12:00:00 AM, mode = RUN, divider = 0, tick_1hz = 0.
//   - Outputs reflect the reset time 1 cycle later: h1=1001111, h2=0010010, others=0000001, ap=A.
//  Storage:
//   - Hours are BCD: h_t (1 bit) + h_o (4 bits), legal range 1..12.
//   - Minutes and seconds are BCD, 00..59. ap is 1 bit (0=AM).
//  Divider:
//   - Counts 0..TICK_DIV-1 in RUN. At terminal count it wraps to 0 and pulses tick_1hz for that cycle.
//   - Held at 0 outside RUN.
//  Advance on tick, with ripple carry in the same cycle:
//   - ss 59 -> 00 carries into mm; mm 59 -> 00 carries into hh.
//   - hh 11 -> 12 toggles ap; hh 12 -> 01 leaves ap unchanged.
//   - 11:59:59 AM -> 12:00:00 PM.  12:59:59 PM -> 01:00:00 PM.
//  Mode FSM: RUN -> SET_HR -> SET_MIN -> RUN, advanced by a debounced BTN_MODE press pulse.
//   - On SET_MIN -> RUN: seconds cleared to 00 and divider restarts from 0.
//  INC press pulse:
//   - SET_HR: hh+1 with the same 11->12 ap toggle and 12->01 wrap.
//   - SET_MIN: mm+1 wraps 59 -> 00 with no carry into hh.
//   - RUN: ignored.
//  Simultaneous events:
//   - MODE and INC pulses in the same cycle: MODE wins, INC is dropped.
//   - Tick cannot coincide with INC, since ticks occur only in RUN.
//  Blink:
//   - A free-running half-second phase runs in set modes (toggles every TICK_DIV/2 cycles).
//   - While the phase is 1, the selected field's two digits output blank.
//  Leading zero: h1 is blank whenever h_t = 0.
//  Output latency: segment outputs are registered, 1 cycle after the internal time or mode changes.
//  RST asserted at any point, including mid-set: immediate return to the reset state.
//   - Pending debounce state is cleared.
//  Buttons: 2-FF synchroniser, then a stable counter, then a rising-edge one-cycle pulse.
//   - Holding a button gives exactly one pulse; there is no auto-repeat.
// STRUCTURE
//  Shared package clock_pkg:
//   - mode enum {RUN, SET_HR, SET_MIN}
//   - SEG_* digit constants, SEG_A, SEG_P, SEG_BLANK
//   - function bcd_to_seg(input [3:0]) returning 7 bits
//  Sub-module btn_debounce #(DEBOUNCE_CYC) (CLK, RST, btn_raw, press_pulse), instantiated twice.
//  Top level holds the divider, the BCD counters, the FSM and the output registers.
// TESTING (TICK_DIV=10, DEBOUNCE_CYC=4)
//  1. Pulse RST for 1 cycle, then release.
//     -> next cycle: h1=1001111, h2=0010010, m*/s*=0000001, ap=0001000; tick_1hz=0.
//  2. Preload 11:59:59 AM via the set sequence, then run 10 cycles.
//     -> one tick_1hz; outputs show 12:00:00, ap=0011000.
//  3. Preload 12:59:59 PM, 1 tick.
//     -> 01:00:00 PM; h1=1111111, h2=1001111.
//  4. MODE press held 20 cycles.
//     -> exactly one transition to SET_HR. Then 3 INC presses from 12 AM -> 03 AM.
//     -> MODE, 61 INC presses -> mm=01 and hh unchanged.
//     -> MODE -> RUN, ss=00, first tick exactly 10 cycles later.
//  5. In SET_HR, MODE and INC debounced pulses land in the same cycle.
//     -> mode=SET_MIN, hh unchanged.
//     Blink check: phase=1 -> m1=m2=1111111, hours still shown.
//  6. Assert RST in SET_MIN with mm=37.
//     -> next cycle mode=RUN, time 12:00:00 AM; no tick for 10 cycles after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and seven-segment constants for the time-of-day clock.
// Segment codes are active-low, bit6 = segment a down to bit0 = segment g.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to single press pulse: 2-FF synchroniser, stability counter,
// then a one-cycle pulse when a new high level is accepted.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync0;
    logic          sync1;
    logic          level;
    logic [CW-1:0] cnt;

    // The accepted level only flips after the synchronised input has
    // disagreed with it for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync0       <= 1'b0;
            sync1       <= 1'b0;
            level       <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync0       <= btn_raw;
            sync1       <= sync0;
            press_pulse <= 1'b0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                cnt         <= '0;
                level       <= sync1;
                press_pulse <= sync1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_time_keeper.sv
// 12-hour hh:mm:ss AM/PM keeper with MODE/INC button time setting and
// registered active-low segment outputs for the VGA clock renderer.
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    output logic [6:0] h1,
    output logic [6:0] h2,
    output logic [6:0] m1,
    output logic [6:0] m2,
    output logic [6:0] s1,
    output logic [6:0] s2,
    output logic [6:0] ap,
    output logic       tick_1hz
);

    localparam int DW   = $clog2(TICK_DIV);
    localparam int HALF = TICK_DIV / 2;
    localparam int BW   = $clog2(HALF + 1);

    mode_t         mode;
    mode_t         mode_next;
    logic [DW-1:0] div;
    logic [BW-1:0] blink_cnt;
    logic          blink;
    logic          h_t;
    logic [3:0]    h_o;
    logic [2:0]    m_t;
    logic [3:0]    m_o;
    logic [2:0]    s_t;
    logic [3:0]    s_o;
    logic          pm;

    logic mode_pulse;
    logic inc_pulse;
    logic tick;
    logic sec_carry;
    logic min_carry;
    logic min_step;
    logic hr_step;
    logic blank_hr;
    logic blank_min;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_btn (
        .CLK         (CLK),
        .RST         (RST),
        .btn_raw     (BTN_MODE),
        .press_pulse (mode_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_btn (
        .CLK         (CLK),
        .RST         (RST),
        .btn_raw     (BTN_INC),
        .press_pulse (inc_pulse)
    );

    // A MODE pulse always takes priority, so an INC in the same cycle is lost.
    always_comb begin
        mode_next = mode;
        if (mode_pulse) begin
            case (mode)
                RUN:     mode_next = SET_HR;
                SET_HR:  mode_next = SET_MIN;
                SET_MIN: mode_next = RUN;
                default: mode_next = RUN;
            endcase
        end
    end

    always_comb begin
        tick      = (mode == RUN) && (div == DW'(TICK_DIV - 1));
        sec_carry = tick && (s_t == 3'd5) && (s_o == 4'd9);
        min_carry = sec_carry && (m_t == 3'd5) && (m_o == 4'd9);
        min_step  = sec_carry || (inc_pulse && !mode_pulse && mode == SET_MIN);
        hr_step   = min_carry || (inc_pulse && !mode_pulse && mode == SET_HR);
        blank_hr  = blink && (mode == SET_HR);
        blank_min = blink && (mode == SET_MIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode      <= RUN;
            div       <= '0;
            tick_1hz  <= 1'b0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            h_t       <= 1'b1;
            h_o       <= 4'd2;
            m_t       <= 3'd0;
            m_o       <= 4'd0;
            s_t       <= 3'd0;
            s_o       <= 4'd0;
            pm        <= 1'b0;
        end else begin
            mode     <= mode_next;
            tick_1hz <= tick;

            if (mode != RUN || mode_next != RUN || tick) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end

            if (mode == RUN) begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end else if (blink_cnt == BW'(HALF - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            if (tick) begin
                if (s_o == 4'd9) begin
                    s_o <= 4'd0;
                    s_t <= (s_t == 3'd5) ? 3'd0 : s_t + 3'd1;
                end else begin
                    s_o <= s_o + 4'd1;
                end
            end else if (mode == SET_MIN && mode_pulse) begin
                s_t <= 3'd0;
                s_o <= 4'd0;
            end

            if (min_step) begin
                if (m_o == 4'd9) begin
                    m_o <= 4'd0;
                    m_t <= (m_t == 3'd5) ? 3'd0 : m_t + 3'd1;
                end else begin
                    m_o <= m_o + 4'd1;
                end
            end

            // The meridiem flips on the 11 -> 12 step, not on the 12 -> 01 wrap.
            if (hr_step) begin
                if (h_t && h_o == 4'd2) begin
                    h_t <= 1'b0;
                    h_o <= 4'd1;
                end else if (h_t && h_o == 4'd1) begin
                    h_o <= 4'd2;
                    pm  <= ~pm;
                end else if (h_o == 4'd9) begin
                    h_t <= 1'b1;
                    h_o <= 4'd0;
                end else begin
                    h_o <= h_o + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h1 <= SEG_1;
            h2 <= SEG_2;
            m1 <= SEG_0;
            m2 <= SEG_0;
            s1 <= SEG_0;
            s2 <= SEG_0;
            ap <= SEG_A;
        end else begin
            h1 <= (blank_hr || !h_t) ? SEG_BLANK : SEG_1;
            h2 <= blank_hr  ? SEG_BLANK : bcd_to_seg(h_o);
            m1 <= blank_min ? SEG_BLANK : bcd_to_seg({1'b0, m_t});
            m2 <= blank_min ? SEG_BLANK : bcd_to_seg(m_o);
            s1 <= bcd_to_seg({1'b0, s_t});
            s2 <= bcd_to_seg(s_o);
            ap <= pm ? SEG_P : SEG_A;
        end
    end

endmodule
